// File: rtl/fader_ramp_if.sv
// Sample/gain bus between a source and fader_ramp. The mute line exists only
// when FADER_MUTE_EN is defined.
interface fader_ramp_if #(
    parameter int BITSIZE  = 16,
    parameter int GAINBITS = 8
);
    logic signed [BITSIZE-1:0] in;
    logic                      in_valid;
    logic [GAINBITS-1:0]       target_gain;
`ifdef FADER_MUTE_EN
    logic                      mute;
`endif
    logic signed [BITSIZE-1:0] out;
    logic                      out_valid;
    logic                      busy;

    modport master (
        output in, in_valid, target_gain,
`ifdef FADER_MUTE_EN
        output mute,
`endif
        input  out, out_valid, busy
    );

    modport slave (
        input  in, in_valid, target_gain,
`ifdef FADER_MUTE_EN
        input  mute,
`endif
        output out, out_valid, busy
    );
endinterface

// File: rtl/fader_ramp.sv
// Click-free gain fader: slew-limited gain, serial shift-add multiply, saturated output.
// Optional FADER_MUTE_EN adds a mute input that ramps the gain to zero.
module fader_ramp #(
    parameter int BITSIZE   = 16,
    parameter int GAINBITS  = 8,
    parameter int RAMP_STEP = 1
) (
    input logic         clk,
    input logic         rst,
    fader_ramp_if.slave bus
);
    localparam int ACCW = BITSIZE + GAINBITS + 1;
    localparam int CW   = $clog2(GAINBITS + 1);
    localparam logic [CW-1:0]       LAST_CNT = CW'(GAINBITS - 1);
    localparam logic [GAINBITS:0]   STEP_W   = (GAINBITS+1)'(RAMP_STEP);
    localparam logic [GAINBITS-1:0] STEP_G   = GAINBITS'(RAMP_STEP);
    localparam logic signed [ACCW-1:0] SAT_MAX =
        {{(ACCW-BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {IDLE, MUL} state_t;

    state_t                    r_state;
    logic [GAINBITS-1:0]       r_gain;
    logic [GAINBITS-1:0]       r_mgain;
    logic signed [ACCW-1:0]    r_acc;
    logic signed [ACCW-1:0]    r_mcand;
    logic [CW-1:0]             r_cnt;
    logic signed [BITSIZE-1:0] r_out;
    logic                      r_out_valid;
    logic                      r_busy;

    logic [GAINBITS-1:0]       w_tgt;
    logic [GAINBITS:0]         w_diff;
    logic [GAINBITS-1:0]       w_next_gain;
    logic signed [ACCW-1:0]    w_sum;
    logic signed [ACCW-1:0]    w_shr;
    logic signed [BITSIZE-1:0] w_res;

    // Slew limiter: step toward the target, snapping when within one step.
    always_comb begin
        w_tgt = bus.target_gain;
`ifdef FADER_MUTE_EN
        if (bus.mute) w_tgt = '0;
`endif
        w_diff = (w_tgt >= r_gain) ? ({1'b0, w_tgt} - {1'b0, r_gain})
                                   : ({1'b0, r_gain} - {1'b0, w_tgt});
        if (w_diff <= STEP_W)      w_next_gain = w_tgt;
        else if (w_tgt > r_gain)   w_next_gain = r_gain + STEP_G;
        else                       w_next_gain = r_gain - STEP_G;
    end

    // Final partial product folded in combinationally so the last MUL edge writes out.
    always_comb begin
        w_sum = r_acc + (r_mgain[0] ? r_mcand : '0);
        w_shr = w_sum >>> (GAINBITS - 1);
        if (w_shr > SAT_MAX)      w_res = {1'b0, {(BITSIZE-1){1'b1}}};
        else if (w_shr < SAT_MIN) w_res = {1'b1, {(BITSIZE-1){1'b0}}};
        else                      w_res = w_shr[BITSIZE-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_gain      <= '0;
            r_mgain     <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_cnt       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_gain  <= w_next_gain;
                        r_mgain <= w_next_gain;
                        r_mcand <= {{(ACCW-BITSIZE){bus.in[BITSIZE-1]}}, bus.in};
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= MUL;
                    end
                end
                MUL: begin
                    r_acc   <= w_sum;
                    r_mcand <= r_mcand <<< 1;
                    r_mgain <= r_mgain >> 1;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_out       <= w_res;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_fader_ramp.sv
// Randomized self-checking bench for fader_ramp against an integer gain/scale model.
module tb_fader_ramp;
    localparam int BS = 16;
    localparam int GB = 8;
    localparam int ST = 1;
    localparam int LAT = GB + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   errors  = 0;
    int   model_gain = 0;

    fader_ramp_if #(.BITSIZE(BS), .GAINBITS(GB)) bus ();

    fader_ramp #(.BITSIZE(BS), .GAINBITS(GB), .RAMP_STEP(ST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic int eff_tgt(input int t, input bit m);
`ifdef FADER_MUTE_EN
        return m ? 0 : t;
`else
        return m ? t : t;
`endif
    endfunction

    function automatic int model_ramp(input int cur, input int tgt);
        int d;
        d = (tgt > cur) ? tgt - cur : cur - tgt;
        if (d <= ST) return tgt;
        return (tgt > cur) ? cur + ST : cur - ST;
    endfunction

    function automatic int model_scale(input int s, input int g);
        longint p;
        p = longint'(s) * longint'(g);
        p = p >>> (GB - 1);
        if (p > 32767)  p = 32767;
        if (p < -32768) p = -32768;
        return int'(p);
    endfunction

    function automatic int rnd_sample();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_gain = 0;
    endtask

    // Presents one sample and observes the following GB+3 cycles.
    task automatic run_sample(input int s, input int tgt, input bit m,
                              output logic signed [BS-1:0] o, output int lat,
                              output int nvalid, output int busy_bad);
        o = '0; lat = -1; nvalid = 0; busy_bad = 0;
        @(negedge clk);
        bus.in = BS'(s);
        bus.target_gain = GB'(tgt);
`ifdef FADER_MUTE_EN
        bus.mute = m;
`endif
        bus.in_valid = 1'b1;
        for (int k = 1; k <= GB + 3; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            if (bus.out_valid === 1'b1) begin
                nvalid++;
                if (lat < 0) lat = k;
                o = bus.out;
            end
            if (bus.busy !== (k <= GB)) busy_bad++;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if (bus.out !== '0) begin errors++; $display("FAIL reset_out: got %0d want 0", bus.out); end
        vectors++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        vectors++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_fade_in();
        logic signed [BS-1:0] o;
        int lat, nv, bb, exp, prev;
        apply_reset();
        prev = -1;
        for (int i = 1; i <= 130; i++) begin
            run_sample(1000, 128, 1'b0, o, lat, nv, bb);
            model_gain = model_ramp(model_gain, 128);
            exp = model_scale(1000, model_gain);
            vectors++;
            if (o !== BS'(exp) || (i == 1 && exp != 7) || (i >= 128 && exp != 1000)) begin
                errors++; $display("FAIL fade_out[%0d]: got %0d want %0d", i, o, exp);
            end
            vectors++;
            if (lat != LAT || nv != 1 || bb != 0) begin
                errors++; $display("FAIL fade_timing[%0d]: lat %0d pulses %0d busy_err %0d want lat %0d", i, lat, nv, bb, LAT);
            end
            vectors++;
            if (int'(o) < prev) begin errors++; $display("FAIL fade_monotonic[%0d]: got %0d after %0d", i, o, prev); end
            prev = int'(o);
        end
    endtask

`ifdef FADER_MUTE_EN
    task automatic test_mute();
        logic signed [BS-1:0] o;
        int lat, nv, bb, exp, prev;
        prev = 32768;
        for (int i = 1; i <= 133; i++) begin
            bit m = (i <= 128);
            run_sample(1000, 128, m, o, lat, nv, bb);
            model_gain = model_ramp(model_gain, eff_tgt(128, m));
            exp = model_scale(1000, model_gain);
            vectors++;
            if (o !== BS'(exp) || lat != LAT || (i == 128 && o !== '0)) begin
                errors++; $display("FAIL mute_out[%0d]: got %0d lat %0d want %0d lat %0d", i, o, lat, exp, LAT);
            end
            if (m) begin
                vectors++;
                if (int'(o) > prev) begin errors++; $display("FAIL mute_monotonic[%0d]: got %0d after %0d", i, o, prev); end
                prev = int'(o);
            end
        end
        bus.mute = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic signed [BS-1:0] o;
        int lat, nv, bb, exp, s, t;
        for (int i = 0; i < 40; i++) begin
            s = rnd_sample();
            t = (i % 8 < 4) ? int'($urandom_range(0, 255)) : model_gain + int'($urandom_range(0, 2)) - 1;
            if (t < 0) t = 0;
            if (t > 255) t = 255;
            run_sample(s, t, 1'b0, o, lat, nv, bb);
            model_gain = model_ramp(model_gain, eff_tgt(t, 1'b0));
            exp = model_scale(s, model_gain);
            vectors++;
            if (o !== BS'(exp) || lat != LAT || nv != 1 || bb != 0) begin
                errors++; $display("FAIL random[%0d]: in %0d got %0d lat %0d want %0d (gain %0d)", i, s, o, lat, exp, model_gain);
            end
        end
    endtask

    task automatic test_saturation();
        logic signed [BS-1:0] o;
        int lat, nv, bb, exp, s;
        for (int i = 0; i < 300 && model_gain != 255; i++) begin
            s = rnd_sample();
            run_sample(s, 255, 1'b0, o, lat, nv, bb);
            model_gain = model_ramp(model_gain, 255);
            exp = model_scale(s, model_gain);
            vectors++;
            if (o !== BS'(exp)) begin errors++; $display("FAIL ramp_up: in %0d got %0d want %0d", s, o, exp); end
        end
        run_sample(32767, 255, 1'b0, o, lat, nv, bb);
        vectors++;
        if (o !== 16'sd32767) begin errors++; $display("FAIL sat_pos: got %0d want 32767", o); end
        run_sample(-32768, 255, 1'b0, o, lat, nv, bb);
        vectors++;
        if (o !== -16'sd32768) begin errors++; $display("FAIL sat_neg: got %0d want -32768", o); end
        apply_reset();
        run_sample(-1, 1, 1'b0, o, lat, nv, bb);
        model_gain = model_ramp(model_gain, 1);
        vectors++;
        if (o !== BS'(model_scale(-1, model_gain)) || o !== -16'sd1) begin
            errors++; $display("FAIL neg_floor: got %0d want -1", o);
        end
    endtask

    task automatic test_ignore();
        logic signed [BS-1:0] o;
        int lat, nv, bb, exp, s;
        s = rnd_sample();
        o = '0; lat = -1; nv = 0; bb = 0;
        @(negedge clk);
        bus.in = BS'(s);
        bus.target_gain = 8'd200;
        bus.in_valid = 1'b1;
        model_gain = model_ramp(model_gain, 200);
        exp = model_scale(s, model_gain);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            bus.in_valid = (k == 3);
            if (k == 3) begin bus.in = 16'sd12345; bus.target_gain = 8'd0; end
            if (bus.out_valid === 1'b1) begin nv++; lat = k; o = bus.out; end
            if (bus.busy !== (k <= GB)) bb++;
        end
        vectors++;
        if (nv != 1 || lat != LAT) begin errors++; $display("FAIL ignore_pulses: got %0d at %0d want 1 at %0d", nv, lat, LAT); end
        vectors++;
        if (o !== BS'(exp)) begin errors++; $display("FAIL ignore_out: got %0d want %0d", o, exp); end
        vectors++;
        if (bb != 0) begin errors++; $display("FAIL ignore_busy: got %0d bad cycles want 0", bb); end
        s = rnd_sample();
        run_sample(s, 200, 1'b0, o, lat, nv, bb);
        model_gain = model_ramp(model_gain, 200);
        exp = model_scale(s, model_gain);
        vectors++;
        if (o !== BS'(exp)) begin errors++; $display("FAIL ignore_gain: got %0d want %0d", o, exp); end
    endtask

    task automatic test_back_to_back();
        int expq[$];
        int sent, got, s, t, exp;
        sent = 0; got = 0;
        @(negedge clk);
        s = rnd_sample(); t = int'($urandom_range(0, 255));
        bus.in = BS'(s); bus.target_gain = GB'(t); bus.in_valid = 1'b1;
        model_gain = model_ramp(model_gain, t);
        expq.push_back(model_scale(s, model_gain));
        sent = 1;
        for (int c = 0; c < 10 * LAT + 30 && got < 10; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            if (bus.out_valid === 1'b1) begin
                exp = (expq.size() > 0) ? expq.pop_front() : 99999;
                got++;
                vectors++;
                if (bus.out !== BS'(exp)) begin errors++; $display("FAIL b2b_out[%0d]: got %0d want %0d", got, bus.out, exp); end
                if (sent < 10) begin
                    s = rnd_sample(); t = int'($urandom_range(0, 255));
                    bus.in = BS'(s); bus.target_gain = GB'(t); bus.in_valid = 1'b1;
                    model_gain = model_ramp(model_gain, t);
                    expq.push_back(model_scale(s, model_gain));
                    sent++;
                end
            end
        end
        vectors++;
        if (got != 10) begin errors++; $display("FAIL b2b_count: got %0d outputs want 10", got); end
    endtask

    task automatic test_reset_mid();
        logic signed [BS-1:0] o;
        int lat, nv, bb;
        nv = 0;
        @(negedge clk);
        bus.in = 16'sd20000; bus.target_gain = 8'd255; bus.in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.out !== '0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_mid: got out %0d valid %b busy %b want 0 0 0", bus.out, bus.out_valid, bus.busy);
        end
        @(negedge clk);
        rst = 1'b0;
        model_gain = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) nv++;
        end
        vectors++;
        if (nv != 0) begin errors++; $display("FAIL reset_abort: got %0d pulses want 0", nv); end
        run_sample(1000, 128, 1'b0, o, lat, nv, bb);
        model_gain = model_ramp(model_gain, 128);
        vectors++;
        if (o !== BS'(model_scale(1000, model_gain))) begin
            errors++; $display("FAIL reset_fade: got %0d want %0d", o, model_scale(1000, model_gain));
        end
    endtask

    initial begin
        bus.in = '0;
        bus.in_valid = 1'b0;
        bus.target_gain = '0;
`ifdef FADER_MUTE_EN
        bus.mute = 1'b0;
`endif
        test_reset();
        test_fade_in();
`ifdef FADER_MUTE_EN
        test_mute();
`endif
        test_random();
        test_saturation();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/fader_ramp.md
FADER_RAMP -- requirements
Module: fader_ramp

Interface
REQ-001 Parameter BITSIZE, default 16: sample width, signed two's complement.
REQ-002 Parameter GAINBITS, default 8: gain width, unsigned Q1.(GAINBITS-1); unity = 2^(GAINBITS-1).
REQ-003 Parameter RAMP_STEP, default 1: maximum gain change per accepted sample.
REQ-004 clk  input  1: single clock; all state updates on rising edge.
REQ-005 rst  input  1: reset, asynchronous, active-high.
REQ-006 in  input  BITSIZE (signed): input sample.
REQ-007 in_valid  input  1: one-cycle strobe, in is valid.
REQ-008 target_gain  input  GAINBITS: requested gain, sampled on acceptance.
REQ-009 mute  input  1: force target to 0 (present only with FADER_MUTE_EN).
REQ-010 out  output  BITSIZE (signed, registered): scaled sample; feeds one mixer channel input.
REQ-011 out_valid  output  1: one-cycle strobe, new out.
REQ-012 busy  output  1: high while a multiply is in progress.

Function
REQ-013 FSM states IDLE, MUL; reset state IDLE.
REQ-014 IDLE: in_valid=1 accepts sample; captures in, updates cur_gain, enters MUL with bit counter = 0.
REQ-015 Gain update on accept: if |target - cur_gain| <= RAMP_STEP then cur_gain = target; else cur_gain moves RAMP_STEP toward target; never overshoots.
REQ-016 Multiply uses the updated cur_gain of the same accepted sample.
REQ-017 MUL: serial shift-add, one gain bit per cycle, exactly GAINBITS cycles; accumulator width >= BITSIZE+GAINBITS+1.
REQ-018 Result = (in * cur_gain) arithmetic-shifted right by GAINBITS-1 (floor), saturated to [-2^(BITSIZE-1), 2^(BITSIZE-1)-1].
REQ-019 On the edge ending the last MUL cycle: out <= result, out_valid pulses, state -> IDLE, busy -> 0.
REQ-020 Latency: in_valid in cycle N -> out_valid high in cycle N+GAINBITS+1, exactly one cycle.
REQ-021 busy high from cycle N+1 to N+GAINBITS inclusive.
REQ-022 in_valid while busy=1 is ignored; sample dropped, cur_gain unchanged.
REQ-023 in_valid in the same cycle as out_valid (state IDLE) is accepted.
REQ-024 out holds its last value between out_valid pulses.
REQ-025 target_gain changes between samples have no effect until the next accept.

Reset
REQ-026 rst=1 forces immediately: state IDLE, out=0, out_valid=0, busy=0, cur_gain=0, accumulator/counter=0.
REQ-027 Reset mid-MUL aborts the operation; no out_valid is produced for the aborted sample.
REQ-028 After reset release, gain ramps up from 0 (fade-in from silence).

Configuration
REQ-029 Macro FADER_MUTE_EN defined: mute port exists; effective target = 0 while mute=1, else target_gain; ramp rules of REQ-015 apply (click-free mute).
REQ-030 FADER_MUTE_EN undefined: mute port absent; effective target = target_gain; behaviour otherwise identical.

Verification (BITSIZE=16, GAINBITS=8, RAMP_STEP=1)
REQ-031 Reset, target=128, in=1000 on every accept -> first out=7 (gain 1), out=1000 from the 128th sample onward, monotonic non-decreasing in between.
REQ-032 cur_gain=255, in=32767 -> out=32767 (saturated); in=-32768 -> out=-32768; in=-1 with gain 1 -> out=-1.
REQ-033 in_valid at cycle N, again at N+3 -> single out_valid at N+9; cur_gain advanced once; busy high N+1..N+8.
REQ-034 Accepts spaced exactly 9 cycles apart (back-to-back) -> every sample produces out_valid, none dropped.
REQ-035 rst asserted at cycle N+4 of a multiply -> out=0, out_valid=0, busy=0 immediately; no later out_valid without a new accept.
REQ-036 FADER_MUTE_EN, cur_gain=128, mute=1, in=1000 -> out decreases per sample, reaches 0 after 128 samples; mute=0 ramps back to target.
